systolic_array_core: RTL
========================

SYSTOLIC_ARRAY_CORE -- requirements
Module: systolic_array_core

Interface
REQ-001 The block SHALL expose the following parameters (name, default, meaning):
- ROWS, 4, PE rows (rows of C)
- COLS, 4, PE columns (columns of C)
- DATA_W, 16, signed operand width
- ACC_W, 40, signed accumulator width (ACC_W >= 2*DATA_W)
- KLEN_W, 16, width of k_len
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous active-low reset
- start, in, 1, begin a job (sampled in IDLE only)
- k_len, in, KLEN_W, inner dimension K (sampled with start)
- acc_mode, in, 1, 1 = accumulate onto retained C, 0 = clear C at start (sampled with start)
- in_valid, in, 1, operand beat valid
- in_ready, out, 1, operand beat accepted
- a_vec, in, ROWS*DATA_W, column k of A (slice i = A[i][k])
- b_vec, in, COLS*DATA_W, row k of B (slice j = B[k][j])
- out_valid, out, 1, result row valid
- out_ready, in, 1, result row consumed
- out_row, out, clog2(ROWS) (min 1), index of row presented
- out_data, out, COLS*ACC_W, C[out_row][0..COLS-1]
- busy, out, 1, high in any state other than IDLE
- done, out, 1, one-cycle pulse on final drain handshake

Function
REQ-003 The block SHALL compute C = A x B (acc_mode=0) or C = C + A x B (acc_mode=1), using a ROWS x COLS output-stationary PE grid, A flowing east, B flowing south.
REQ-004 Products SHALL be signed DATA_W x DATA_W, sign-extended to ACC_W; accumulation wraps modulo 2^ACC_W, no saturation.
REQ-005 Input skew registers SHALL delay row i of A by i enabled steps and column j of B by j enabled steps.
REQ-006 The grid and skew registers SHALL advance only on an enabled step: an in_valid&&in_ready beat in STREAM, or any FLUSH cycle (zeros injected); bubbles freeze the grid, so results are independent of in_valid gaps.
REQ-007 FSM states SHALL be IDLE, STREAM, FLUSH, DRAIN.
REQ-008 IDLE: in_ready=0, out_valid=0; start=1 latches k_len/acc_mode, clears accumulators and skew registers if acc_mode=0, clears skew registers only if acc_mode=1; next state STREAM if k_len>0, else DRAIN.
REQ-009 STREAM: in_ready=1; beat counter increments per handshake; handshake on beat k_len-1 -> FLUSH.
REQ-010 FLUSH: in_ready=0; exactly ROWS+COLS-1 cycles, then DRAIN.
REQ-011 DRAIN: out_valid=1, out_row starts at 0; out_data stable while out_valid&&!out_ready; each handshake increments out_row; handshake on row ROWS-1 -> IDLE with done=1 that cycle.
REQ-012 start SHALL be ignored while busy=1.
REQ-013 k_len=0 SHALL drain the current accumulators (zeros if acc_mode=0, retained values if acc_mode=1).
REQ-014 Accumulators SHALL retain values after DRAIN until a later start with acc_mode=0 or reset.
REQ-015 Latency from final operand handshake to out_valid SHALL be ROWS+COLS cycles.

Reset
REQ-016 rst low SHALL asynchronously force state IDLE, all counters, skew registers and accumulators to 0, in_ready=0, out_valid=0, out_row=0, out_data=0, busy=0, done=0.
REQ-017 Reset asserted mid-job SHALL abandon the job; no done pulse, no partial output afterwards.
REQ-018 Deassertion SHALL be synchronised externally; the block leaves reset in IDLE on the first clk edge with rst high.

Structure
REQ-019 A shared package systolic_pkg SHALL hold the FSM state enum, default DATA_W/ACC_W/KLEN_W constants and the sign-extension helper.
REQ-020 The MAC cell SHALL be a sub-module sa_pe (enable, clear, a/b pass-through registers, accumulator), instantiated ROWS*COLS times via generate.
REQ-021 Skew registers, FSM and drain mux SHALL live in systolic_array_core.

Verification
REQ-022 Bench SHALL cover (4x4, DATA_W=16, ACC_W=40):
- A=identity, B[k][j]=4k+j, K=4, acc_mode=0, in_valid always high -> rows out {0,1,2,3},{4..7},{8..11},{12..15}, done pulse once, out_valid rises exactly 8 cycles after last beat.
- Same job with in_valid random 50% and out_ready random 50% -> identical C, out_data stable while stalled.
- All-ones A and B, K=3, acc_mode=0, then repeat with acc_mode=1 -> first every C=3, second every C=6.
- A=-32768, B=-32768 everywhere, K=256 -> every C = 2^38 (no wrap); ACC_W=32 build -> every C wraps to 0.
- k_len=0, acc_mode=0 after a prior job -> four zero rows, done pulse; start pulsed during DRAIN -> ignored.
- rst low on 2nd STREAM beat -> all outputs 0 within same cycle, no done; fresh job afterwards -> correct C.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and helpers for the output-stationary systolic matrix-multiply core.
package systolic_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 40;
  localparam int KLEN_W_DEF = 16;
  localparam int SEXT_MAX_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN
  } sa_state_e;

  // Treat bit w-1 of v as the sign and replicate it across the upper bits.
  function automatic logic signed [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] v,
                                                         input int unsigned w);
    int unsigned sh;
    sh = SEXT_MAX_W - w;
    return $signed(v << sh) >>> sh;
  endfunction

endpackage

// File: rtl/sa_pe.sv
// Output-stationary MAC cell: forwards a east and b south, accumulates a*b in place.
module sa_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic                     i_clr_acc,
  input  logic                     i_clr_pipe,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [DATA_W-1:0] o_a,
  output logic signed [DATA_W-1:0] o_b,
  output logic signed [ACC_W-1:0]  o_acc
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;

  assign w_prod     = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
  assign w_prod_ext = ACC_W'(sext(SEXT_MAX_W'($unsigned(w_prod)), 2*DATA_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_a   <= '0;
      o_b   <= '0;
      o_acc <= '0;
    end else begin
      if (i_clr_pipe) begin
        o_a <= '0;
        o_b <= '0;
      end else if (i_en) begin
        o_a <= i_a;
        o_b <= i_b;
      end
      // Accumulation wraps modulo 2^ACC_W by design.
      if (i_clr_acc)
        o_acc <= '0;
      else if (i_en)
        o_acc <= o_acc + w_prod_ext;
    end
  end

endmodule

// File: rtl/systolic_array_core.sv
// ROWS x COLS output-stationary systolic array: skewed operand injection, flush, row-wise drain.
module systolic_array_core
  import systolic_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int KLEN_W = KLEN_W_DEF,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [KLEN_W-1:0]      k_len,
  input  logic                   acc_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_vec,
  input  logic [COLS*DATA_W-1:0] b_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROW_W-1:0]       out_row,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   busy,
  output logic                   done
);

  localparam int FLUSH_LEN = ROWS + COLS - 1;
  localparam int FL_W      = $clog2(FLUSH_LEN + 1);

  sa_state_e           r_state, w_state_nxt;
  logic [KLEN_W-1:0]   r_klen;
  logic [KLEN_W-1:0]   r_beat;
  logic [FL_W-1:0]     r_flush;
  logic [ROW_W-1:0]    r_row;
  logic                w_step;
  logic                w_clr_acc;
  logic                w_clr_pipe;

  logic signed [DATA_W-1:0] w_a_h [ROWS][COLS+1];
  logic signed [DATA_W-1:0] w_b_v [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  w_acc [ROWS][COLS];
  logic [ROWS+COLS-1:0]     w_unused_edge;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    w_step      = 1'b0;
    w_clr_acc   = 1'b0;
    w_clr_pipe  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_clr_pipe  = 1'b1;
          w_clr_acc   = !acc_mode;
          w_state_nxt = (k_len != '0) ? ST_STREAM : ST_DRAIN;
        end
      end
      ST_STREAM: begin
        in_ready = 1'b1;
        w_step   = in_valid;
        if (in_valid && (r_beat == r_klen - KLEN_W'(1)))
          w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        w_step = 1'b1;
        if (r_flush == FL_W'(FLUSH_LEN - 1))
          w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (r_row == ROW_W'(ROWS - 1))) begin
          done        = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_klen  <= '0;
      r_beat  <= '0;
      r_flush <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_klen  <= k_len;
            r_beat  <= '0;
            r_flush <= '0;
            r_row   <= '0;
          end
        end
        ST_STREAM: if (in_valid) r_beat <= r_beat + KLEN_W'(1);
        ST_FLUSH:  r_flush <= r_flush + FL_W'(1);
        ST_DRAIN: begin
          if (out_ready)
            r_row <= (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + ROW_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign out_row = r_row;

  // Row i of A enters i steps late; zeros are injected outside STREAM.
  for (genvar i = 0; i < ROWS; i++) begin : g_askew
    logic signed [DATA_W-1:0] w_in;
    assign w_in = (r_state == ST_STREAM) ? $signed(a_vec[i*DATA_W +: DATA_W]) : '0;
    if (i == 0) begin : g_direct
      assign w_a_h[i][0] = w_in;
    end else begin : g_dly
      logic signed [DATA_W-1:0] r_sk [0:i-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < i; s++) r_sk[s] <= '0;
        end else if (w_clr_pipe) begin
          for (int s = 0; s < i; s++) r_sk[s] <= '0;
        end else if (w_step) begin
          r_sk[0] <= w_in;
          for (int s = 1; s < i; s++) r_sk[s] <= r_sk[s-1];
        end
      end
      assign w_a_h[i][0] = r_sk[i-1];
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bskew
    logic signed [DATA_W-1:0] w_in;
    assign w_in = (r_state == ST_STREAM) ? $signed(b_vec[j*DATA_W +: DATA_W]) : '0;
    if (j == 0) begin : g_direct
      assign w_b_v[0][j] = w_in;
    end else begin : g_dly
      logic signed [DATA_W-1:0] r_sk [0:j-1];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < j; s++) r_sk[s] <= '0;
        end else if (w_clr_pipe) begin
          for (int s = 0; s < j; s++) r_sk[s] <= '0;
        end else if (w_step) begin
          r_sk[0] <= w_in;
          for (int s = 1; s < j; s++) r_sk[s] <= r_sk[s-1];
        end
      end
      assign w_b_v[0][j] = r_sk[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_step),
        .i_clr_acc  (w_clr_acc),
        .i_clr_pipe (w_clr_pipe),
        .i_a        (w_a_h[i][j]),
        .i_b        (w_b_v[i][j]),
        .o_a        (w_a_h[i][j+1]),
        .o_b        (w_b_v[i+1][j]),
        .o_acc      (w_acc[i][j])
      );
    end
  end

  // Operands leaving the far edges of the grid carry no further meaning.
  for (genvar i = 0; i < ROWS; i++) begin : g_east_edge
    assign w_unused_edge[i] = ^w_a_h[i][COLS];
  end
  for (genvar j = 0; j < COLS; j++) begin : g_south_edge
    assign w_unused_edge[ROWS+j] = ^w_b_v[ROWS][j];
  end

  always_comb begin
    out_data = '0;
    if (r_state == ST_DRAIN) begin
      for (int j = 0; j < COLS; j++)
        out_data[j*ACC_W +: ACC_W] = w_acc[r_row][j];
    end
  end

endmodule
